// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU.
// Retires BPC result bits per CALC cycle. All outputs come straight from flops.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned N    = WIDTH / BPC;
    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFixup, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     shifted, sum;
    logic               ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // abs(MIN) wraps to MIN, which read unsigned is exactly 2^(W-1).
    assign abs_a = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;

    assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        step_acc = acc_q;
        shifted  = '0;
        sum      = '0;
        ge       = 1'b0;
        for (int i = 0; i < int'(BPC); i++) begin
            if (op_q[1]) begin
                shifted  = {step_acc[2*WIDTH-1:WIDTH], step_acc[WIDTH-1]};
                ge       = shifted >= {1'b0, b_q};
                step_acc = {(ge ? shifted[WIDTH-1:0] - b_q : shifted[WIDTH-1:0]),
                            step_acc[WIDTH-2:0], ge};
            end else begin
                sum      = {1'b0, step_acc[2*WIDTH-1:WIDTH]} +
                           (step_acc[0] ? {1'b0, a_q} : '0);
                step_acc = {sum, step_acc[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        dbz_d    = dbz_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StPrep;
                    op_d    = op_i;
                    a_d     = opa_i;
                    b_d     = opb_i;
                end
            end
            StPrep: begin
                sa_d  = op_q[0] & a_q[WIDTH-1];
                sb_d  = op_q[0] & b_q[WIDTH-1];
                a_d   = abs_a;
                b_d   = abs_b;
                cnt_d = '0;
                if (op_q[1] && (b_q == '0)) begin
                    state_d  = StDone;
                    res_hi_d = a_q;
                    res_lo_d = '1;
                    dbz_d    = 1'b1;
                end else begin
                    state_d = StCalc;
                    acc_d   = {{WIDTH{1'b0}}, (op_q[1] ? abs_a : abs_b)};
                end
            end
            StCalc: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                state_d = StDone;
                dbz_d   = 1'b0;
                if (op_q[1]) begin
                    res_hi_d = rem_fix;
                    res_lo_d = quo_fix;
                end else begin
                    res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    res_lo_d = prod_fix[WIDTH-1:0];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An annulled op must leave the visible results untouched.
        if (flush_i) begin
            state_d  = StIdle;
            dbz_d    = dbz_q;
            res_hi_d = res_hi_q;
            res_lo_d = res_lo_q;
        end

        busy_d  = (state_d != StIdle);
        ready_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            dbz_q    <= dbz_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign busy_o        = busy_q;
    assign ready_o       = ready_q;
    assign result_hi_o   = res_hi_q;
    assign result_lo_o   = res_lo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed cases on a BPC=1 instance, randomized ops on a BPC=4
// instance, all checked against a plain-arithmetic model of the operation semantics.
module tb_muldiv_iter;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic        sel   = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] opa   = '0;
    logic [31:0] opb   = '0;

    logic        busy1, ready1, dbz1, busy4, ready4, dbz4;
    logic [31:0] hi1, lo1, hi4, lo4;
    logic        start1, start4, flush1, flush4;
    logic        m_busy, m_ready, m_dbz;
    logic [31:0] m_hi, m_lo;

    assign start1  = start & ~sel;
    assign start4  = start & sel;
    assign flush1  = flush & ~sel;
    assign flush4  = flush & sel;
    assign m_busy  = sel ? busy4 : busy1;
    assign m_ready = sel ? ready4 : ready1;
    assign m_dbz   = sel ? dbz4 : dbz1;
    assign m_hi    = sel ? hi4 : hi1;
    assign m_lo    = sel ? lo4 : lo1;

    muldiv_iter #(.WIDTH(32), .BPC(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush1), .start_i(start1), .op_i(op),
        .opa_i(opa), .opb_i(opb), .busy_o(busy1), .ready_o(ready1), .result_hi_o(hi1),
        .result_lo_o(lo1), .div_by_zero_o(dbz1)
    );

    muldiv_iter #(.WIDTH(32), .BPC(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush4), .start_i(start4), .op_i(op),
        .opa_i(opa), .opb_i(opb), .busy_o(busy4), .ready_o(ready4), .result_hi_o(hi4),
        .result_lo_o(lo4), .div_by_zero_o(dbz4)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          mcyc     = 0;
    logic [31:0] hold_hi  = '0;
    logic [31:0] hold_lo  = '0;
    logic        hold_dbz = 1'b0;
    logic        pend_rst = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Operation semantics in 64-bit arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz);
        logic [63:0]        p;
        logic signed [63:0] sa, sb, q, r;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        dbz = 1'b0;
        p   = '0;
        if (o == 2'b00) begin
            p = {32'b0, a} * {32'b0, b};
        end else if (o == 2'b01) begin
            p = sa * sb;
        end else if (b == 32'b0) begin
            dbz = 1'b1;
            p   = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
            p = {a % b, a / b};
        end else begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Posedge: note what the DUT accepted / annulled. Negedge: compare outputs.
    task automatic monitor();
        exp_t        e;
        logic [31:0] eh, el;
        logic        ed;
        forever begin
            @(clk);
            if (clk) begin
                mcyc++;
                if (rst) begin
                    exp_q.delete();
                    hold_hi  = '0;
                    hold_lo  = '0;
                    hold_dbz = 1'b0;
                    pend_rst = 1'b1;
                end else begin
                    pend_rst = 1'b0;
                    if (flush) begin
                        exp_q.delete();
                    end else if (start && !m_busy) begin
                        e.op  = op;
                        e.a   = opa;
                        e.b   = opb;
                        e.t0  = mcyc;
                        e.lat = (op[1] && opb == 32'b0) ? 2 : ((sel ? 8 : 32) + 3);
                        exp_q.push_back(e);
                    end
                end
            end else if (pend_rst) begin
                chk("rst_busy", 32'(m_busy), 0);
                chk("rst_ready", 32'(m_ready), 0);
                chk("rst_hi", m_hi, 0);
                chk("rst_lo", m_lo, 0);
                chk("rst_dbz", 32'(m_dbz), 0);
            end else if (m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready=1 expected 0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    model(e.op, e.a, e.b, eh, el, ed);
                    chk("latency", 32'(mcyc - e.t0 + 1), 32'(e.lat));
                    chk("res_hi", m_hi, eh);
                    chk("res_lo", m_lo, el);
                    chk("res_dbz", 32'(m_dbz), 32'(ed));
                    hold_hi  = eh;
                    hold_lo  = el;
                    hold_dbz = ed;
                end
            end else begin
                chk("hold_hi", m_hi, hold_hi);
                chk("hold_lo", m_lo, hold_lo);
                chk("hold_dbz", 32'(m_dbz), 32'(hold_dbz));
            end
        end
    endtask

    // Called right after a negedge; returns one negedge after start was sampled.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (m_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("issue_idle", 32'(m_busy), 0);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(m_busy), 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic expect_res(input string name, input logic [31:0] h, input logic [31:0] l,
                              input logic d);
        chk({name, "_hi"}, m_hi, h);
        chk({name, "_lo"}, m_lo, l);
        chk({name, "_dbz"}, 32'(m_dbz), 32'(d));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("rst4_busy", 32'(busy4), 0);
        chk("rst4_ready", 32'(ready4), 0);
        chk("rst4_hi", hi4, 0);
        chk("rst4_lo", lo4, 0);
        rst = 1'b0;

        // Directed cases, BPC=1.
        issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
        drain();
        expect_res("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        expect_res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        drain();
        expect_res("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        expect_res("div_min", 32'h0000_0000, 32'h8000_0000, 1'b0);
        issue(2'b10, 32'h1234_5678, 32'h0000_0000);
        drain();
        expect_res("divu_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);

        // Flush at CALC cycle 10.
        issue(2'b10, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(m_busy), 0);
        repeat (40) @(negedge clk);
        expect_res("after_flush", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        issue(2'b00, 32'd6, 32'd7);
        drain();
        expect_res("multu_6x7", 32'h0, 32'h0000_002A, 1'b0);

        // Start re-pulsed while busy with a different operand.
        issue(2'b00, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        opa   = 32'd9;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();
        expect_res("busy_start", 32'h0, 32'h0000_000F, 1'b0);

        // flush and start together in IDLE.
        op    = 2'b00;
        opa   = 32'd2;
        opb   = 32'd2;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", 32'(m_busy), 0);
        repeat (40) @(negedge clk);
        chk("flush_start_none", 32'(exp_q.size()), 0);
        expect_res("flush_start", 32'h0, 32'h0000_000F, 1'b0);

        // Randomized ops on BPC=4, with one reset landing mid-CALC.
        sel = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(2'($urandom_range(0, 3)), pick(), pick());
            if (i == 500) begin
                op = 2'b00;
                issue(op, 32'hDEAD_BEEF, 32'h0000_0003);
                repeat (4) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                expect_res("mid_rst", 32'h0, 32'h0, 1'b0);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
